// File: rtl/mem_stage_if.sv
// Request/response bundle between the MEM pipeline stage and memacc_ctrl.
// The stage drives a held request; the controller answers with a one-cycle done pulse.
interface mem_stage_if;
  logic [1:0]  rw_to_ctrl;
  logic [31:0] addr_to_ctrl;
  logic [31:0] data_to_ctrl;
  logic [4:0]  bits_to_ctrl;
  logic [31:0] data_from_ctrl;
  logic        done_from_ctrl;

  modport master (
    output rw_to_ctrl, addr_to_ctrl, data_to_ctrl, bits_to_ctrl,
    input  data_from_ctrl, done_from_ctrl
  );

  modport slave (
    input  rw_to_ctrl, addr_to_ctrl, data_to_ctrl, bits_to_ctrl,
    output data_from_ctrl, done_from_ctrl
  );
endinterface

// File: rtl/mem_stage.sv
// RISC-V MEM stage: issues loads/stores to memacc_ctrl, stalls until done,
// extends load data and forwards the writeback bundle to MEM/WB.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] sdata_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  mem_stage_if.master ctrl
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef struct packed {
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  bits;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] ldata_q, ldata_d;
  logic [31:0] ext;
  logic        mem_op;

  assign mem_op = load_i | store_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ldata_q <= ldata_d;
    end
  end

  // Bits above the access width from the controller are don't-care.
  always_comb begin
    ext = ctrl.data_from_ctrl;
    case (funct3_i)
      3'b000:  ext = {{24{ctrl.data_from_ctrl[7]}},  ctrl.data_from_ctrl[7:0]};
      3'b001:  ext = {{16{ctrl.data_from_ctrl[15]}}, ctrl.data_from_ctrl[15:0]};
      3'b100:  ext = {24'd0, ctrl.data_from_ctrl[7:0]};
      3'b101:  ext = {16'd0, ctrl.data_from_ctrl[15:0]};
      default: ext = ctrl.data_from_ctrl;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ldata_d = ldata_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          req_d.rw   = store_i ? 2'b10 : 2'b01;
          req_d.addr = addr_i;
          req_d.data = sdata_i;
          case (funct3_i[1:0])
            2'b00:   req_d.bits = 5'd7;
            2'b01:   req_d.bits = 5'd15;
            default: req_d.bits = 5'd31;
          endcase
          state_d = BUSY;
        end else begin
          req_d = '0;
        end
      end
      BUSY: begin
        if (ctrl.done_from_ctrl) begin
          ldata_d  = ext;
          req_d.rw = 2'b00;
          state_d  = DONE;
        end
      end
      // DONE releases the stall for exactly one cycle so the instruction is not re-issued.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = ((state_q == IDLE) && mem_op) || (state_q == BUSY);
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = ((state_q == DONE) && load_i) ? ldata_q : wdata_i;
  end

  assign ctrl.rw_to_ctrl   = req_q.rw;
  assign ctrl.addr_to_ctrl = req_q.addr;
  assign ctrl.data_to_ctrl = req_q.data;
  assign ctrl.bits_to_ctrl = req_q.bits;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected requests and writebacks,
// a monitor pops and compares them as the DUT presents them.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        load_i, store_i, wreg_i, instr_vld;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, sdata_i, wdata_i, wdata_o;
  logic [4:0]  wd_i, wd_o;
  logic        wreg_o, stallreq_o;

  mem_stage_if mif();

  mem_stage dut (
    .clk(clk), .rst(rst),
    .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .sdata_i(sdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o), .ctrl(mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  bits;
  } req_s;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } wb_s;

  req_s req_q[$];
  wb_s  wb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: request on each rising rw, hold while active, writeback when the pipe advances.
  initial begin
    logic [1:0] prev_rw;
    req_s cur;
    wb_s  w;
    prev_rw = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mif.rw_to_ctrl != 2'b00 && prev_rw == 2'b00) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: got rw %0d addr 0x%08h, expected no request",
                     mif.rw_to_ctrl, mif.addr_to_ctrl);
          end else begin
            cur = req_q.pop_front();
            chk("req_rw",   {30'd0, mif.rw_to_ctrl}, {30'd0, cur.rw});
            chk("req_addr", mif.addr_to_ctrl, cur.addr);
            chk("req_data", mif.data_to_ctrl, cur.data);
            chk("req_bits", {27'd0, mif.bits_to_ctrl}, {27'd0, cur.bits});
          end
        end else if (mif.rw_to_ctrl != 2'b00) begin
          chk("hold_rw",   {30'd0, mif.rw_to_ctrl}, {30'd0, cur.rw});
          chk("hold_addr", mif.addr_to_ctrl, cur.addr);
          chk("hold_data", mif.data_to_ctrl, cur.data);
          chk("hold_bits", {27'd0, mif.bits_to_ctrl}, {27'd0, cur.bits});
        end
        if (instr_vld && !stallreq_o) begin
          if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected: got wdata 0x%08h, expected no writeback", wdata_o);
          end else begin
            w = wb_q.pop_front();
            chk("wb_wd",    {27'd0, wd_o}, {27'd0, w.wd});
            chk("wb_wreg",  {31'd0, wreg_o}, {31'd0, w.wreg});
            chk("wb_wdata", wdata_o, w.wdata);
          end
        end
      end
      prev_rw = mif.rw_to_ctrl;
    end
  end

  // Presents one EX/MEM instruction and plays memacc_ctrl: done comes dly cycles after rw is seen.
  task automatic issue(input string nm, input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] wd, input bit wreg, input logic [31:0] wdata,
                       input int dly, input logic [31:0] rdata,
                       input logic [31:0] exp_wdata, input logic [4:0] exp_bits,
                       input bit spurious);
    int cyc = 0;
    int rw_seen = -1;
    int stalls = 0;
    bit fin = 0;
    load_i = ld; store_i = st; funct3_i = f3; addr_i = addr; sdata_i = sdata;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata; instr_vld = 1'b1;
    wb_q.push_back(wb_s'{wd, wreg, exp_wdata});
    if (ld | st) req_q.push_back(req_s'{(st ? 2'b10 : 2'b01), addr, sdata, exp_bits});
    while (!fin && cyc < 50) begin
      if (rw_seen < 0 && mif.rw_to_ctrl != 2'b00) rw_seen = cyc;
      mif.done_from_ctrl = (ld | st) ? (rw_seen >= 0 && cyc == rw_seen + dly) : spurious;
      mif.data_from_ctrl = rdata;
      @(negedge clk);
      if (stallreq_o) stalls++; else fin = 1;
      @(posedge clk); #1;
      mif.done_from_ctrl = 1'b0;
      cyc++;
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no pipeline advance in 50 cycles, expected advance", nm);
    end
    chk({nm, "_stall_cycles"}, stalls, (ld | st) ? dly + 2 : 0);
    instr_vld = 1'b0; load_i = 1'b0; store_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; instr_vld = 1'b0;
    load_i = 1'b0; store_i = 1'b0; funct3_i = 3'b000; addr_i = '0; sdata_i = '0;
    wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    mif.data_from_ctrl = '0; mif.done_from_ctrl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rw",    {30'd0, mif.rw_to_ctrl}, 32'd0);
    chk("rst_addr",  mif.addr_to_ctrl, 32'd0);
    chk("rst_data",  mif.data_to_ctrl, 32'd0);
    chk("rst_bits",  {27'd0, mif.bits_to_ctrl}, 32'd0);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // LW abandoned by reset while BUSY
    load_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h40; sdata_i = '0;
    req_q.push_back(req_s'{2'b01, 32'h40, 32'h0, 5'd31});
    @(posedge clk); #1;
    chk("busy_stall", {31'd0, stallreq_o}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0; #1;
    chk("midrst_rw",    {30'd0, mif.rw_to_ctrl}, 32'd0);
    chk("midrst_addr",  mif.addr_to_ctrl, 32'd0);
    chk("midrst_stall", {31'd0, stallreq_o}, 32'd1);
    load_i = 1'b0; #1;
    chk("midrst_idle_stall", {31'd0, stallreq_o}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("post_rst_rw",    {30'd0, mif.rw_to_ctrl}, 32'd0);

    //     name    ld st f3      addr          sdata         wd  wr wdata         dly rdata          exp           bits spur
    issue("lb",    1, 0, 3'b000, 32'h100,      32'h0,        3,  1, 32'hAAAA,     3,  32'h000000F3,  32'hFFFFFFF3, 7,   0);
    issue("lb_pos",1, 0, 3'b000, 32'h101,      32'h0,        4,  1, 32'h0,        1,  32'hABCDE07F,  32'h0000007F, 7,   0);
    issue("lbu",   1, 0, 3'b100, 32'h102,      32'h0,        4,  1, 32'h0,        2,  32'h12345680,  32'h00000080, 7,   0);
    issue("lhu",   1, 0, 3'b101, 32'h202,      32'h0,        6,  1, 32'h0,        1,  32'h00008001,  32'h00008001, 15,  0);
    issue("lh",    1, 0, 3'b001, 32'h204,      32'h0,        6,  1, 32'h0,        2,  32'h00008001,  32'hFFFF8001, 15,  0);
    issue("sw",    0, 1, 3'b010, 32'h2000,     32'hDEADBEEF, 0,  0, 32'h55,       2,  32'h0,         32'h55,       31,  0);
    issue("lw",    1, 0, 3'b010, 32'h300,      32'h0,        7,  1, 32'h99,       0,  32'h11223344,  32'h11223344, 31,  0);
    issue("sb",    0, 1, 3'b000, 32'h3003,     32'h000000AB, 0,  0, 32'h77,       0,  32'h0,         32'h77,       7,   0);
    issue("alu",   0, 0, 3'b000, 32'h0,        32'h0,        5,  1, 32'h1234,     0,  32'hFFFFFFFF,  32'h1234,     0,   1);
    chk("alu_rw_after",    {30'd0, mif.rw_to_ctrl}, 32'd0);
    chk("alu_stall_after", {31'd0, stallreq_o}, 32'd0);
    issue("lw2",   1, 0, 3'b010, 32'h400,      32'h0,        9,  1, 32'h0,        1,  32'hCAFEF00D,  32'hCAFEF00D, 31,  0);

    repeat (3) @(posedge clk);
    #1;
    chk("req_queue_empty", req_q.size(), 32'd0);
    chk("wb_queue_empty",  wb_q.size(),  32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
